// File: rtl/keypad_pkg.sv
// Shared types, key map and scan classification for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;
    localparam int NUM_KEYS = NUM_COLS * NUM_ROWS;

    typedef logic [1:0] col_idx_t;
    typedef logic [3:0] line_vec_t;
    typedef logic [3:0] key_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        REL_DB
    } kp_state_e;

    typedef enum logic [1:0] {
        NONE,
        KEY,
        MULTI
    } scan_res_e;

    typedef struct packed {
        scan_res_e res;
        key_idx_t  idx;
    } scan_class_t;

    // Indexed by col*4 + row; Pmod KYPD legend.
    localparam logic [3:0] KEY_MAP [NUM_KEYS] = '{
        4'h1, 4'h4, 4'h7, 4'h0,
        4'h2, 4'h5, 4'h8, 4'hF,
        4'h3, 4'h6, 4'h9, 4'hE,
        4'hA, 4'hB, 4'hC, 4'hD
    };

    function automatic scan_class_t classify(input logic [NUM_KEYS-1:0] snap);
        scan_class_t r;
        int unsigned n;
        n     = 0;
        r.idx = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (snap[i]) begin
                n++;
                r.idx = key_idx_t'(i);
            end
        end
        if (n == 0) begin
            r.res = NONE;
        end else if (n == 1) begin
            r.res = KEY;
        end else begin
            r.res = MULTI;
        end
        return r;
    endfunction

endpackage

// File: rtl/keypad_col_timer.sv
// Column driver: holds each active-low column for SCAN_DIV clocks and flags
// the last clock of each column as the row sample point.
module keypad_col_timer
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic      CLK,
    input  logic      RST_N,
    output line_vec_t cols,
    output col_idx_t  col_idx,
    output logic      sample
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    col_idx_t         col_q, col_d;
    line_vec_t        cols_q, cols_d;
    logic             div_last;

    assign div_last = (div_q == DIV_W'(SCAN_DIV - 1));

    always_comb begin
        div_d  = div_q + DIV_W'(1);
        col_d  = col_q;
        if (div_last) begin
            div_d = '0;
            col_d = col_q + 2'd1;
        end
        cols_d = ~(4'b0001 << col_d);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_q  <= '0;
            col_q  <= '0;
            cols_q <= 4'b1110;
        end else begin
            div_q  <= div_d;
            col_q  <= col_d;
            cols_q <= cols_d;
        end
    end

    assign cols    = cols_q;
    assign col_idx = col_q;
    assign sample  = div_last;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: synchronises row returns, builds a 16-key snapshot per
// scan, debounces single-key presses and presents them on a valid/ack port.
//
// state    | meaning
// IDLE     | nothing held; waiting for a single-key scan
// PRESS_DB | candidate key seen, counting identical scans
// HELD     | key accepted and still down (no rollover)
// REL_DB   | empty scans seen, counting toward release
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] ROWS,
    output logic [3:0] COLS,
    output logic [3:0] KEY_CODE,
    output logic       KEY_VALID,
    input  logic       KEY_ACK,
    output logic       KEY_PRESSED,
    output logic       OVERRUN
);

    localparam int CNT_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;

    col_idx_t         col_idx;
    logic             col_sample;

    line_vec_t        rows_s1_q, rows_s1_d, rows_s2_q, rows_s2_d;
    logic             sample_p1_q, sample_p1_d, sample_p2_q, sample_p2_d;
    col_idx_t         col_p1_q, col_p1_d, col_p2_q, col_p2_d;
    logic [11:0]      snap_q, snap_d;
    line_vec_t        pressed_now;
    logic [15:0]      full_snap;
    logic             scan_done;
    scan_class_t      cls;

    kp_state_e        state_q;
    key_idx_t         cand_q;
    logic [CNT_W-1:0] cnt_q, cnt_inc;
    logic             cnt_done;
    logic             accept_q;
    logic             pressed_q;

    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             overrun_q, overrun_d;
    logic             ack_hit;

    keypad_col_timer #(
        .SCAN_DIV (SCAN_DIV)
    ) u_col_timer (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .cols    (COLS),
        .col_idx (col_idx),
        .sample  (col_sample)
    );

    // Strobe and column index are delayed to match the row synchroniser, so the
    // sample sees the rows as they were on the column's last driven clock.
    always_comb begin
        rows_s1_d   = ROWS;
        rows_s2_d   = rows_s1_q;
        sample_p1_d = col_sample;
        sample_p2_d = sample_p1_q;
        col_p1_d    = col_idx;
        col_p2_d    = col_p1_q;
        snap_d      = snap_q;
        if (sample_p2_q) begin
            case (col_p2_q)
                2'd0:    snap_d[3:0]  = pressed_now;
                2'd1:    snap_d[7:4]  = pressed_now;
                2'd2:    snap_d[11:8] = pressed_now;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rows_s1_q   <= 4'hF;
            rows_s2_q   <= 4'hF;
            sample_p1_q <= 1'b0;
            sample_p2_q <= 1'b0;
            col_p1_q    <= '0;
            col_p2_q    <= '0;
            snap_q      <= '0;
        end else begin
            rows_s1_q   <= rows_s1_d;
            rows_s2_q   <= rows_s2_d;
            sample_p1_q <= sample_p1_d;
            sample_p2_q <= sample_p2_d;
            col_p1_q    <= col_p1_d;
            col_p2_q    <= col_p2_d;
            snap_q      <= snap_d;
        end
    end

    assign pressed_now = ~rows_s2_q;
    assign full_snap   = {pressed_now, snap_q};
    assign scan_done   = sample_p2_q && (col_p2_q == 2'd3);
    assign cls         = classify(full_snap);
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign cnt_done    = (cnt_inc == CNT_W'(DEBOUNCE_SCANS));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            cand_q    <= '0;
            cnt_q     <= '0;
            accept_q  <= 1'b0;
            pressed_q <= 1'b0;
        end else begin
            accept_q <= 1'b0;
            if (scan_done) begin
                case (state_q)
                    IDLE: begin
                        if (cls.res == KEY) begin
                            cand_q <= cls.idx;
                            cnt_q  <= CNT_W'(1);
                            if (DEBOUNCE_SCANS == 1) begin
                                state_q   <= HELD;
                                accept_q  <= 1'b1;
                                pressed_q <= 1'b1;
                            end else begin
                                state_q <= PRESS_DB;
                            end
                        end
                    end
                    PRESS_DB: begin
                        if (cls.res == KEY && cls.idx == cand_q) begin
                            cnt_q <= cnt_inc;
                            if (cnt_done) begin
                                state_q   <= HELD;
                                accept_q  <= 1'b1;
                                pressed_q <= 1'b1;
                            end
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    HELD: begin
                        if (cls.res == NONE) begin
                            cnt_q <= CNT_W'(1);
                            if (DEBOUNCE_SCANS == 1) begin
                                state_q   <= IDLE;
                                pressed_q <= 1'b0;
                            end else begin
                                state_q <= REL_DB;
                            end
                        end
                    end
                    REL_DB: begin
                        if (cls.res == NONE) begin
                            cnt_q <= cnt_inc;
                            if (cnt_done) begin
                                state_q   <= IDLE;
                                pressed_q <= 1'b0;
                            end
                        end else begin
                            state_q <= HELD;
                        end
                    end
                    default: begin
                        state_q   <= IDLE;
                        pressed_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // An accept always wins over a coincident ack; the ack only suppresses overrun.
    always_comb begin
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        overrun_d   = overrun_q;
        ack_hit     = KEY_ACK && key_valid_q;
        if (accept_q) begin
            key_code_d  = KEY_MAP[cand_q];
            key_valid_d = 1'b1;
            if (key_valid_q) begin
                overrun_d = !KEY_ACK;
            end
        end else if (ack_hit) begin
            key_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign KEY_CODE    = key_code_q;
    assign KEY_VALID   = key_valid_q;
    assign OVERRUN     = overrun_q;
    assign KEY_PRESSED = pressed_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_SCANS=2 (16-cycle scans).
// A behavioural keypad drives ROWS from COLS and a 16-bit pressed-key vector.
module tb_keypad_scan;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [3:0]  ROWS;
    logic [3:0]  COLS;
    logic [3:0]  KEY_CODE;
    logic        KEY_VALID;
    logic        KEY_ACK = 1'b0;
    logic        KEY_PRESSED;
    logic        OVERRUN;

    logic [15:0] keys = '0;
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;

    keypad_scan #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .ROWS        (ROWS),
        .COLS        (COLS),
        .KEY_CODE    (KEY_CODE),
        .KEY_VALID   (KEY_VALID),
        .KEY_ACK     (KEY_ACK),
        .KEY_PRESSED (KEY_PRESSED),
        .OVERRUN     (OVERRUN)
    );

    always #5 CLK = ~CLK;

    // Cycle index: value seen at a negedge is the number of edges since reset release.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always_comb begin
        ROWS = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[c*4+r] && !COLS[c]) ROWS[r] = 1'b0;
            end
        end
    end

    task automatic do_reset(input logic [15:0] k);
        @(negedge CLK);
        RST_N   = 1'b0;
        KEY_ACK = 1'b0;
        keys    = k;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic wait_cyc(input int t);
        int g;
        g = 0;
        while (cyc < t && g < 20000) begin
            @(negedge CLK);
            g++;
        end
    endtask

    task automatic ack_pulse(input int t);
        wait_cyc(t);
        KEY_ACK = 1'b1;
        @(negedge CLK);
        KEY_ACK = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_cols;
        logic [1:0] c;
        do_reset(16'h0000);
        for (int t = 0; t < 100; t++) begin
            wait_cyc(t);
            c = 2'((t / 4) % 4);
            exp_cols = ~(4'b0001 << c);
            n_total++;
            if (COLS !== exp_cols || KEY_CODE !== 4'h0 || {KEY_VALID, KEY_PRESSED, OVERRUN} !== 3'b000)
                $display("FAIL reset_idle t=%0d: cols=%b code=%h v/p/o=%b%b%b, want cols=%b code=0 v/p/o=000",
                         t, COLS, KEY_CODE, KEY_VALID, KEY_PRESSED, OVERRUN, exp_cols);
            else n_pass++;
        end
        wait_cyc(102);
        n_total++;
        if (COLS !== 4'b1101) $display("FAIL pre_async_reset_cols: got %b want 1101", COLS);
        else n_pass++;
        #2 RST_N = 1'b0;
        #1;
        n_total++;
        if (COLS !== 4'b1110) $display("FAIL async_reset_cols: got %b want 1110", COLS);
        else n_pass++;
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_press_5();
        do_reset(16'h0020);
        wait_cyc(34);
        n_total++;
        if (KEY_VALID !== 1'b0) $display("FAIL press5_early_valid: got %b want 0", KEY_VALID);
        else n_pass++;
        wait_cyc(35);
        n_total++;
        if (KEY_VALID !== 1'b1 || KEY_CODE !== 4'h5 || KEY_PRESSED !== 1'b1 || OVERRUN !== 1'b0)
            $display("FAIL press5_accept: v=%b code=%h p=%b o=%b, want v=1 code=5 p=1 o=0",
                     KEY_VALID, KEY_CODE, KEY_PRESSED, OVERRUN);
        else n_pass++;
        ack_pulse(40);
        n_total++;
        if (KEY_VALID !== 1'b0 || KEY_PRESSED !== 1'b1)
            $display("FAIL press5_ack: v=%b p=%b, want v=0 p=1", KEY_VALID, KEY_PRESSED);
        else n_pass++;
        wait_cyc(48);
        keys = 16'h0000;
        wait_cyc(81);
        n_total++;
        if (KEY_PRESSED !== 1'b1) $display("FAIL press5_release_early: pressed=%b want 1", KEY_PRESSED);
        else n_pass++;
        wait_cyc(82);
        n_total++;
        if (KEY_PRESSED !== 1'b0 || KEY_VALID !== 1'b0)
            $display("FAIL press5_release: p=%b v=%b, want p=0 v=0", KEY_PRESSED, KEY_VALID);
        else n_pass++;
    endtask

    task automatic test_bounce();
        logic seen;
        seen = 1'b0;
        do_reset(16'h8000);
        for (int t = 0; t <= 129; t++) begin
            wait_cyc(t);
            if (t == 16 || t == 48 || t == 80) keys = 16'h0000;
            if (t == 32 || t == 64 || t == 96) keys = 16'h8000;
            if (KEY_VALID || KEY_PRESSED) seen = 1'b1;
        end
        n_total++;
        if (seen !== 1'b0) $display("FAIL bounce_no_event: seen=%b want 0", seen);
        else n_pass++;
        wait_cyc(131);
        n_total++;
        if (KEY_VALID !== 1'b1 || KEY_CODE !== 4'hD || KEY_PRESSED !== 1'b1)
            $display("FAIL bounce_stable_D: v=%b code=%h p=%b, want v=1 code=D p=1",
                     KEY_VALID, KEY_CODE, KEY_PRESSED);
        else n_pass++;
    endtask

    task automatic test_multi_no_rollover();
        logic seen, dropped;
        seen = 1'b0;
        dropped = 1'b0;
        do_reset(16'h0001);
        wait_cyc(35);
        n_total++;
        if (KEY_VALID !== 1'b1 || KEY_CODE !== 4'h1)
            $display("FAIL multi_first_1: v=%b code=%h, want v=1 code=1", KEY_VALID, KEY_CODE);
        else n_pass++;
        ack_pulse(40);
        for (int t = 41; t <= 145; t++) begin
            wait_cyc(t);
            if (t == 48)  keys = 16'h0011;
            if (t == 80)  keys = 16'h0010;
            if (t == 112) keys = 16'h0000;
            if (KEY_VALID) seen = 1'b1;
            if (!KEY_PRESSED) dropped = 1'b1;
        end
        n_total++;
        if (seen !== 1'b0 || dropped !== 1'b0)
            $display("FAIL multi_held: valid_seen=%b pressed_dropped=%b, want 0 0", seen, dropped);
        else n_pass++;
        wait_cyc(146);
        n_total++;
        if (KEY_PRESSED !== 1'b0) $display("FAIL multi_full_release: pressed=%b want 0", KEY_PRESSED);
        else n_pass++;
        for (int t = 146; t <= 178; t++) begin
            wait_cyc(t);
            if (t == 146) keys = 16'h0010;
            if (KEY_VALID) seen = 1'b1;
        end
        n_total++;
        if (seen !== 1'b0 || KEY_CODE !== 4'h1)
            $display("FAIL multi_pre_2: valid_seen=%b code=%h, want 0 and 1", seen, KEY_CODE);
        else n_pass++;
        wait_cyc(179);
        n_total++;
        if (KEY_VALID !== 1'b1 || KEY_CODE !== 4'h2)
            $display("FAIL multi_then_2: v=%b code=%h, want v=1 code=2", KEY_VALID, KEY_CODE);
        else n_pass++;
    endtask

    task automatic test_overrun();
        do_reset(16'h1000);
        wait_cyc(35);
        n_total++;
        if (KEY_VALID !== 1'b1 || KEY_CODE !== 4'hA || OVERRUN !== 1'b0)
            $display("FAIL ovr_accept_A: v=%b code=%h o=%b, want v=1 code=A o=0", KEY_VALID, KEY_CODE, OVERRUN);
        else n_pass++;
        wait_cyc(48);
        keys = 16'h0000;
        wait_cyc(96);
        keys = 16'h0100;
        wait_cyc(130);
        n_total++;
        if (KEY_VALID !== 1'b1 || KEY_CODE !== 4'hA || OVERRUN !== 1'b0)
            $display("FAIL ovr_before_3: v=%b code=%h o=%b, want v=1 code=A o=0", KEY_VALID, KEY_CODE, OVERRUN);
        else n_pass++;
        wait_cyc(131);
        n_total++;
        if (KEY_VALID !== 1'b1 || KEY_CODE !== 4'h3 || OVERRUN !== 1'b1)
            $display("FAIL ovr_set: v=%b code=%h o=%b, want v=1 code=3 o=1", KEY_VALID, KEY_CODE, OVERRUN);
        else n_pass++;
        ack_pulse(135);
        n_total++;
        if (KEY_VALID !== 1'b0 || OVERRUN !== 1'b0)
            $display("FAIL ovr_ack_clear: v=%b o=%b, want v=0 o=0", KEY_VALID, OVERRUN);
        else n_pass++;
        wait_cyc(144);
        keys = 16'h0000;
        wait_cyc(192);
        keys = 16'h1000;
        wait_cyc(227);
        n_total++;
        if (KEY_VALID !== 1'b1 || KEY_CODE !== 4'hA || OVERRUN !== 1'b0)
            $display("FAIL ovr_second_A: v=%b code=%h o=%b, want v=1 code=A o=0", KEY_VALID, KEY_CODE, OVERRUN);
        else n_pass++;
        wait_cyc(240);
        keys = 16'h0000;
        wait_cyc(288);
        keys = 16'h0100;
        ack_pulse(322);
        n_total++;
        if (KEY_VALID !== 1'b1 || KEY_CODE !== 4'h3 || OVERRUN !== 1'b0)
            $display("FAIL ovr_ack_on_accept: v=%b code=%h o=%b, want v=1 code=3 o=0",
                     KEY_VALID, KEY_CODE, OVERRUN);
        else n_pass++;
        wait_cyc(324);
        n_total++;
        if (KEY_VALID !== 1'b1) $display("FAIL ovr_valid_kept: v=%b want 1", KEY_VALID);
        else n_pass++;
    endtask

    task automatic test_release_bounce();
        logic seen, dropped;
        seen = 1'b0;
        dropped = 1'b0;
        do_reset(16'h0080);
        wait_cyc(35);
        n_total++;
        if (KEY_VALID !== 1'b1 || KEY_CODE !== 4'hF || KEY_PRESSED !== 1'b1)
            $display("FAIL relb_accept_F: v=%b code=%h p=%b, want v=1 code=F p=1", KEY_VALID, KEY_CODE, KEY_PRESSED);
        else n_pass++;
        ack_pulse(40);
        for (int t = 41; t <= 140; t++) begin
            wait_cyc(t);
            if (t == 48) keys = 16'h0000;
            if (t == 64) keys = 16'h0080;
            if (KEY_VALID) seen = 1'b1;
            if (!KEY_PRESSED) dropped = 1'b1;
        end
        n_total++;
        if (seen !== 1'b0 || dropped !== 1'b0)
            $display("FAIL relb_glitch: valid_seen=%b pressed_dropped=%b, want 0 0", seen, dropped);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_press_5();
        test_bounce();
        test_multi_no_rollover();
        test_overrun();
        test_release_bounce();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
